// File: rtl/seg7_pkg.sv
// seg7_pkg: segment-pattern constants and shared types for the seven-segment reader
package seg7_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;
  localparam seg_t SEG_PAT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seg7_reader_if.sv
// seg7_reader_if: decoded-frame output bus (value/err/out_valid/overrun out, out_ready in; dp with SEG7_READER_DP_EN)
interface seg7_reader_if #(parameter int NDIG = 4);
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
`ifdef SEG7_READER_DP_EN
  logic [NDIG-1:0]   dp;
  modport master (input out_ready, output value, err, out_valid, overrun, dp);
  modport slave  (output out_ready, input value, err, out_valid, overrun, dp);
`else
  modport master (input out_ready, output value, err, out_valid, overrun);
  modport slave  (output out_ready, input value, err, out_valid, overrun);
`endif
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low segment pattern (seg_n) to nibble; err flags patterns not in the table
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t    seg_n,
  output nibble_t nibble,
  output logic    err
);
  always_comb begin
    nibble = '0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg_n == SEG_PAT[i]) begin
        nibble = nibble_t'(i);
        err    = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: samples a multiplexed 7-segment display and emits decoded frames
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   seg_n        : active-low segments, bit0=a .. bit6=g
//   dig_en       : one-hot digit select
//   bus (master) : value/err/out_valid/overrun out, out_ready in
//   SEG7_READER_DP_EN adds dp_n input and bus.dp output
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int NDIG       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  seg_t            seg_n,
`ifdef SEG7_READER_DP_EN
  input  logic            dp_n,
`endif
  input  logic [NDIG-1:0] dig_en,
  seg7_reader_if.master   bus
);
  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
  localparam logic [7:0] PRE  = 8'(STABLE_CYC - 2);
  seg_t              prev_seg;
  logic [NDIG-1:0]   prev_dig, seen, stage_err;
  logic [4*NDIG-1:0] stage_val;
  logic [7:0]        stab_cnt;
  logic              armed, onehot, same, dp_same, cap, done, bad;
  nibble_t           nibble;
  seg7_pattern_decode u_dec (.seg_n(seg_n), .nibble(nibble), .err(bad));
`ifdef SEG7_READER_DP_EN
  logic            prev_dp;
  logic [NDIG-1:0] stage_dp;
  assign dp_same = dp_n == prev_dp;
`else
  assign dp_same = 1'b1;
`endif
  always_comb begin
    onehot = |dig_en && ~|(dig_en & (dig_en - 1'b1));
    same   = onehot && seg_n == prev_seg && dig_en == prev_dig && dp_same;
    // armed drops after a capture so a held digit is taken only once per visit
    cap    = same && stab_cnt == PRE && armed;
    done   = &seen;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg      <= 7'h7F;
      prev_dig      <= '0;
      stab_cnt      <= '0;
      armed         <= 1'b1;
      seen          <= '0;
      stage_val     <= '0;
      stage_err     <= '0;
      bus.value     <= '0;
      bus.err       <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      prev_seg <= seg_n;
      prev_dig <= dig_en;
      stab_cnt <= !same ? '0 : stab_cnt == LAST ? stab_cnt : stab_cnt + 1'b1;
      armed    <= dig_en != prev_dig ? 1'b1 : cap ? 1'b0 : armed;
      for (int i = 0; i < NDIG; i++)
        if (cap && dig_en[i]) begin
          stage_val[4*i +: 4] <= nibble;
          stage_err[i]        <= bad;
        end
      seen <= (done ? '0 : seen) | (cap ? dig_en : '0);
      if (done && (!bus.out_valid || bus.out_ready)) begin
        bus.out_valid <= 1'b1;
        bus.value     <= stage_val;
        bus.err       <= stage_err;
      end else begin
        if (done) bus.overrun <= 1'b1;
        if (bus.out_ready) bus.out_valid <= 1'b0;
      end
    end
  end
`ifdef SEG7_READER_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dp  <= 1'b1;
      stage_dp <= '0;
      bus.dp   <= '0;
    end else begin
      prev_dp <= dp_n;
      for (int i = 0; i < NDIG; i++)
        if (cap && dig_en[i]) stage_dp[i] <= ~dp_n;
      if (done && (!bus.out_valid || bus.out_ready)) bus.dp <= stage_dp;
    end
  end
`endif
endmodule
